// File: rtl/fpu_arbiter.sv
// Round-robin arbiter sharing one FPU between NUM_REQ requesters.
// Requests are queued as pending bits, issued one at a time, and results routed back to the owner.
module fpu_arbiter #(
  parameter int NUM_REQ = 3,
  localparam int RR_W = $clog2(NUM_REQ)
) (
  input  logic              clk,
  input  logic              reset_i,
  input  logic [3:0]        req_op_i          [NUM_REQ],
  input  logic [31:0]       req_a_value_i     [NUM_REQ],
  input  logic [31:0]       req_b_value_i     [NUM_REQ],
  input  logic              req_exec_strobe_i [NUM_REQ],
  output logic [31:0]       req_z_value_o     [NUM_REQ],
  output logic              req_done_strobe_o [NUM_REQ],
  output logic [3:0]        fpu_op_o,
  output logic [31:0]       fpu_a_value_o,
  output logic [31:0]       fpu_b_value_o,
  input  logic [31:0]       fpu_z_value_i,
  output logic              fpu_exec_strobe_o,
  input  logic              fpu_done_strobe_i,
  output logic [1:0]        dbg_state_o,
  output logic [RR_W-1:0]   dbg_rr_o
);

  // Handshake: a requester pulses req_exec_strobe_i for one cycle and holds op/a/b until
  // the arbiter latches them; the FPU gets a one-cycle fpu_exec_strobe_o and answers with
  // a one-cycle fpu_done_strobe_i; the owner then sees a one-cycle req_done_strobe_o.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_RESPOND = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [NUM_REQ-1:0] r_pending;
  logic [RR_W-1:0]    r_rr;
  logic [RR_W-1:0]    r_g;
  logic [NUM_REQ-1:0] w_set;
  logic [NUM_REQ-1:0] w_clr;
  logic               w_any;
  logic [RR_W-1:0]    w_grant;
  logic [RR_W-1:0]    w_next_rr;
  logic               w_launch;
  logic               w_finish;

  assign dbg_state_o = r_state;
  assign dbg_rr_o    = r_rr;
  assign w_launch    = (r_state == S_IDLE) && w_any;
  assign w_finish    = (r_state == S_WAIT) && fpu_done_strobe_i;

  // Scan descending so the index closest to r_rr is written last and wins.
  always_comb begin
    w_any   = 1'b0;
    w_grant = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (r_pending[(int'(r_rr) + k) % NUM_REQ]) begin
        w_any   = 1'b1;
        w_grant = RR_W'((int'(r_rr) + k) % NUM_REQ);
      end
    end
    w_next_rr = (int'(w_grant) == NUM_REQ - 1) ? '0 : w_grant + 1'b1;
  end

  always_comb begin
    w_set = '0;
    w_clr = '0;
    for (int i = 0; i < NUM_REQ; i++) w_set[i] = req_exec_strobe_i[i];
    if (r_state == S_RESPOND) w_clr[r_g] = 1'b1;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_any) w_next = S_ISSUE;
      S_ISSUE:   w_next = S_WAIT;
      S_WAIT:    if (fpu_done_strobe_i) w_next = S_RESPOND;
      S_RESPOND: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_state           <= S_IDLE;
      r_pending         <= '0;
      r_rr              <= '0;
      r_g               <= '0;
      fpu_op_o          <= '0;
      fpu_a_value_o     <= '0;
      fpu_b_value_o     <= '0;
      fpu_exec_strobe_o <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
        req_z_value_o[i]     <= '0;
        req_done_strobe_o[i] <= 1'b0;
      end
    end else begin
      r_state           <= w_next;
      // A strobe from the owner during RESPOND is swallowed because the clear wins.
      r_pending         <= (r_pending | w_set) & ~w_clr;
      fpu_exec_strobe_o <= w_launch;
      for (int i = 0; i < NUM_REQ; i++) req_done_strobe_o[i] <= 1'b0;
      if (w_launch) begin
        r_g           <= w_grant;
        r_rr          <= w_next_rr;
        fpu_op_o      <= req_op_i[w_grant];
        fpu_a_value_o <= req_a_value_i[w_grant];
        fpu_b_value_o <= req_b_value_i[w_grant];
      end
      if (w_finish) begin
        req_z_value_o[r_g]     <= fpu_z_value_i;
        req_done_strobe_o[r_g] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fpu_arbiter.sv
// Bench for fpu_arbiter: stub FPU (z = a ^ b, programmable latency), directed requests,
// scoreboard queues for expected issues and expected done pulses checked by a monitor.
module tb_fpu_arbiter;
  localparam int N = 3;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic [3:0]  req_op_i          [N];
  logic [31:0] req_a_value_i     [N];
  logic [31:0] req_b_value_i     [N];
  logic        req_exec_strobe_i [N];
  logic [31:0] req_z_value_o     [N];
  logic        req_done_strobe_o [N];
  logic [3:0]  fpu_op_o;
  logic [31:0] fpu_a_value_o;
  logic [31:0] fpu_b_value_o;
  logic [31:0] fpu_z_value_i = '0;
  logic        fpu_exec_strobe_o;
  logic        fpu_done_strobe_i = 1'b0;
  logic [1:0]  dbg_state_o;
  logic [1:0]  dbg_rr_o;

  fpu_arbiter #(.NUM_REQ(N)) dut (
    .clk               (clk),
    .reset_i           (reset_i),
    .req_op_i          (req_op_i),
    .req_a_value_i     (req_a_value_i),
    .req_b_value_i     (req_b_value_i),
    .req_exec_strobe_i (req_exec_strobe_i),
    .req_z_value_o     (req_z_value_o),
    .req_done_strobe_o (req_done_strobe_o),
    .fpu_op_o          (fpu_op_o),
    .fpu_a_value_o     (fpu_a_value_o),
    .fpu_b_value_o     (fpu_b_value_o),
    .fpu_z_value_i     (fpu_z_value_i),
    .fpu_exec_strobe_o (fpu_exec_strobe_o),
    .fpu_done_strobe_i (fpu_done_strobe_i),
    .dbg_state_o       (dbg_state_o),
    .dbg_rr_o          (dbg_rr_o)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [67:0] exp_iss_q[$];   // {op, a, b}
  logic [66:0] exp_done_q[$];  // {idx[2:0], z, cycle (0 = untimed)}
  int          exec_count = 0;
  logic [31:0] held_a = '0;
  logic [31:0] held_b = '0;
  logic [67:0] mon_e;
  logic [66:0] mon_d;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- stub FPU ----------------
  int          lat = 3;
  int          stub_cnt = 0;
  logic [31:0] stub_z = '0;
  always @(negedge clk) begin
    fpu_done_strobe_i = 1'b0;
    if (stub_cnt > 0) begin
      stub_cnt--;
      if (stub_cnt == 0) begin
        fpu_done_strobe_i = 1'b1;
        fpu_z_value_i     = stub_z;
      end
    end
    if (fpu_exec_strobe_o) begin
      stub_cnt = lat;
      stub_z   = fpu_a_value_o ^ fpu_b_value_o;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (fpu_exec_strobe_o) begin
      exec_count++;
      held_a = fpu_a_value_o;
      held_b = fpu_b_value_o;
      if (exp_iss_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_issue: got op %h a %h b %h expected none", fpu_op_o, fpu_a_value_o, fpu_b_value_o);
      end else begin
        mon_e = exp_iss_q.pop_front();
        check("issue_op", 32'(fpu_op_o), 32'(mon_e[67:64]));
        check("issue_a", fpu_a_value_o, mon_e[63:32]);
        check("issue_b", fpu_b_value_o, mon_e[31:0]);
      end
    end
    if (dbg_state_o == 2'd2 || dbg_state_o == 2'd3) begin
      check("hold_a", fpu_a_value_o, held_a);
      check("hold_b", fpu_b_value_o, held_b);
    end
    for (int i = 0; i < N; i++) begin
      if (req_done_strobe_o[i]) begin
        if (exp_done_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done on req %0d z %h expected none", i, req_z_value_o[i]);
        end else begin
          mon_d = exp_done_q.pop_front();
          check("done_idx", 32'(i), 32'(mon_d[66:64]));
          check("done_z", req_z_value_o[i], mon_d[63:32]);
          if (mon_d[31:0] != 0) check("done_cycle", 32'(cyc), mon_d[31:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op_i[i]      = op;
    req_a_value_i[i] = a;
    req_b_value_i[i] = b;
  endtask

  task automatic push_iss(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_iss_q.push_back({op, a, b});
  endtask

  task automatic push_done(input int idx, input logic [31:0] z, input int c);
    exp_done_q.push_back({3'(idx), z, 32'(c)});
  endtask

  task automatic pulse(input logic [N-1:0] mask, input int n, output int t0);
    @(negedge clk);
    for (int i = 0; i < N; i++) req_exec_strobe_i[i] = mask[i];
    t0 = cyc;
    repeat (n) @(negedge clk);
    for (int i = 0; i < N; i++) req_exec_strobe_i[i] = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (exp_iss_q.size() == 0 && exp_done_q.size() == 0 && dbg_state_o == 2'd0) break;
    end
    check(name, 32'(k < 300), 32'd1);
    repeat (6) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_fpu_op"}, 32'(fpu_op_o), 32'd0);
    check({tag, "_fpu_a"}, fpu_a_value_o, 32'd0);
    check({tag, "_fpu_b"}, fpu_b_value_o, 32'd0);
    check({tag, "_fpu_exec"}, 32'(fpu_exec_strobe_o), 32'd0);
    check({tag, "_state"}, 32'(dbg_state_o), 32'd0);
    check({tag, "_rr"}, 32'(dbg_rr_o), 32'd0);
    for (int i = 0; i < N; i++) begin
      check({tag, "_z"}, req_z_value_o[i], 32'd0);
      check({tag, "_done"}, 32'(req_done_strobe_o[i]), 32'd0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int t0;
    int ec0;
    int k;
    for (int i = 0; i < N; i++) begin
      req_exec_strobe_i[i] = 1'b0;
      set_req(i, 4'h0, 32'h0, 32'h0);
    end
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset_i = 1'b0;
    @(negedge clk);

    // All three strobe together: issue order 0, 1, 2.
    lat = 2;
    set_req(0, 4'h1, 32'h40000000, 32'h3f800000);
    set_req(1, 4'h2, 32'h41200000, 32'h40a00000);
    set_req(2, 4'h3, 32'hc0490fdb, 32'h402df854);
    push_iss(4'h1, 32'h40000000, 32'h3f800000);
    push_iss(4'h2, 32'h41200000, 32'h40a00000);
    push_iss(4'h3, 32'hc0490fdb, 32'h402df854);
    push_done(0, 32'h7f800000, 0);
    push_done(1, 32'h01800000, 0);
    push_done(2, 32'h8064f78f, 0);
    ec0 = exec_count;
    pulse(3'b111, 1, t0);
    wait_idle("all_idle");
    check("all_exec_count", 32'(exec_count - ec0), 32'd3);
    check("all_rr", 32'(dbg_rr_o), 32'd0);

    // Single request from requester 1, L=3.
    lat = 3;
    set_req(1, 4'h2, 32'h3f800000, 32'h3f000000);
    push_iss(4'h2, 32'h3f800000, 32'h3f000000);
    ec0 = exec_count;
    pulse(3'b010, 1, t0);
    push_done(1, 32'h00800000, t0 + 6);
    @(negedge clk);
    check("single_exec_time", 32'(fpu_exec_strobe_o), 32'd1);
    check("single_exec_op", 32'(fpu_op_o), 32'd2);
    wait_idle("single_idle");
    check("single_exec_count", 32'(exec_count - ec0), 32'd1);
    check("single_rr", 32'(dbg_rr_o), 32'd2);

    // Rotation: rr=2, requesters 0 and 2 strobe together -> 2 then 0.
    set_req(0, 4'h5, 32'hdeadbeef, 32'hffffffff);
    set_req(2, 4'h7, 32'h12345678, 32'h0f0f0f0f);
    push_iss(4'h7, 32'h12345678, 32'h0f0f0f0f);
    push_iss(4'h5, 32'hdeadbeef, 32'hffffffff);
    push_done(2, 32'h1d3b5977, 0);
    push_done(0, 32'h21524110, 0);
    pulse(3'b101, 1, t0);
    wait_idle("rot_idle");
    check("rot_rr", 32'(dbg_rr_o), 32'd1);

    // Duplicate strobe, then re-strobe in the cycle after the done pulse.
    lat = 2;
    set_req(0, 4'h9, 32'haaaa5555, 32'h5555aaaa);
    push_iss(4'h9, 32'haaaa5555, 32'h5555aaaa);
    push_done(0, 32'hffffffff, 0);
    ec0 = exec_count;
    pulse(3'b001, 2, t0);
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (req_done_strobe_o[0]) break;
    end
    check("dup_done_seen", 32'(k < 50), 32'd1);
    set_req(0, 4'ha, 32'h00000001, 32'h80000000);
    push_iss(4'ha, 32'h00000001, 32'h80000000);
    pulse(3'b001, 1, t0);
    push_done(0, 32'h80000001, t0 + lat + 3);
    wait_idle("dup_idle");
    check("dup_exec_count", 32'(exec_count - ec0), 32'd2);

    // Reset while WAIT, L=5; late done must be ignored.
    lat = 5;
    set_req(0, 4'h4, 32'h00000001, 32'h00000002);
    push_iss(4'h4, 32'h00000001, 32'h00000002);
    pulse(3'b001, 1, t0);
    for (k = 0; k < 20; k++) begin
      if (dbg_state_o == 2'd2) break;
      @(negedge clk);
    end
    check("rst_reached_wait", 32'(k < 20), 32'd1);
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    check_reset_outputs("rst_wait");
    repeat (12) @(negedge clk);
    set_req(2, 4'h6, 32'hcafef00d, 32'h0000ffff);
    push_iss(4'h6, 32'hcafef00d, 32'h0000ffff);
    pulse(3'b100, 1, t0);
    push_done(2, 32'hcafe0ff2, t0 + 8);
    wait_idle("rst_idle");

    // Latency sweep L=1 and L=8.
    lat = 1;
    set_req(2, 4'h8, 32'h3f800000, 32'h00000001);
    push_iss(4'h8, 32'h3f800000, 32'h00000001);
    pulse(3'b100, 1, t0);
    push_done(2, 32'h3f800001, t0 + 4);
    wait_idle("l1_idle");
    lat = 8;
    set_req(0, 4'hb, 32'h7f7fffff, 32'h00800000);
    push_iss(4'hb, 32'h7f7fffff, 32'h00800000);
    pulse(3'b001, 1, t0);
    push_done(0, 32'h7fffffff, t0 + 11);
    wait_idle("l8_idle");

    check("final_iss_q_empty", 32'(exp_iss_q.size()), 32'd0);
    check("final_done_q_empty", 32'(exp_done_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
